// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for the shared scratch memory.
// Zero-fills the whole memory after reset or clr before serving anyone.
//
// state | meaning
// INIT  | sweeping write(k, 0) over every address, no grants
// RUN   | arbitrating A/B, one registered access per cycle
module mem_arbiter #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              a_gnt,
   output logic              b_gnt,
   output logic              a_rvalid,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              init_busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {INIT, RUN} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   cnt, cnt_nxt;
   logic                last_b, last_b_nxt;
   logic                en_nxt, we_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [DATA_W-1:0]   wdata_nxt;
   logic [1:0]          rd_a_pipe, rd_b_pipe;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      last_b_nxt = last_b;
      a_gnt      = 1'b0;
      b_gnt      = 1'b0;
      en_nxt     = 1'b0;
      we_nxt     = 1'b0;
      addr_nxt   = mem_addr;
      wdata_nxt  = mem_wdata;
      case (state)
         INIT: begin
            en_nxt    = 1'b1;
            we_nxt    = 1'b1;
            addr_nxt  = cnt;
            wdata_nxt = '0;
            cnt_nxt   = cnt + 1'b1;
            if (&cnt) state_nxt = RUN;
         end
         RUN: begin
            if (clr) begin
               state_nxt = INIT;
               cnt_nxt   = '0;
            // on a tie, A wins only if B was granted last
            end else if (a_req && (!b_req || last_b)) begin
               a_gnt      = 1'b1;
               last_b_nxt = 1'b0;
               en_nxt     = 1'b1;
               we_nxt     = a_we;
               addr_nxt   = a_addr;
               wdata_nxt  = a_wdata;
            end else if (b_req) begin
               b_gnt      = 1'b1;
               last_b_nxt = 1'b1;
               en_nxt     = 1'b1;
               we_nxt     = b_we;
               addr_nxt   = b_addr;
               wdata_nxt  = b_wdata;
            end
         end
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         cnt       <= '0;
         last_b    <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_a_pipe <= '0;
         rd_b_pipe <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         last_b    <= last_b_nxt;
         mem_en    <= en_nxt;
         mem_we    <= we_nxt;
         mem_addr  <= addr_nxt;
         mem_wdata <= wdata_nxt;
         // not cleared by clr so reads already issued still return
         rd_a_pipe <= {rd_a_pipe[0], a_gnt & ~a_we};
         rd_b_pipe <= {rd_b_pipe[0], b_gnt & ~b_we};
      end
   end

   assign init_busy = (state == INIT);
   assign a_rvalid  = rd_a_pipe[1];
   assign b_rvalid  = rd_b_pipe[1];
   assign rdata     = mem_rdata;

endmodule
